// File: rtl/rf_port_master.sv
// Command front-end for a two-read / one-write register file: reads, writes
// and a clear-all sweep, with a valid/ready request port and a read response port.
module rf_port_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [ADDR_WIDTH-1:0] req_addr_a,
  input  logic [ADDR_WIDTH-1:0] req_addr_b,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data_a,
  output logic [DATA_WIDTH-1:0] rsp_data_b,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [ADDR_WIDTH-1:0] rf_raddr1,
  output logic [ADDR_WIDTH-1:0] rf_raddr2,
  output logic                  rf_wen,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  input  logic [DATA_WIDTH-1:0] rf_rdata1,
  input  logic [DATA_WIDTH-1:0] rf_rdata2
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD   = 3'd1;
  localparam logic [2:0] RSP  = 3'd2;
  localparam logic [2:0] WR   = 3'd3;
  localparam logic [2:0] CLR  = 3'd4;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = {ADDR_WIDTH{1'b1}};
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

  logic [2:0]            state_r,   state_s;
  logic [ADDR_WIDTH-1:0] addr_a_r,  addr_a_s;
  logic [ADDR_WIDTH-1:0] addr_b_r,  addr_b_s;
  logic [DATA_WIDTH-1:0] wdata_r,   wdata_s;
  logic [ADDR_WIDTH-1:0] clr_cnt_r, clr_cnt_s;
  logic                  hs_s;
  logic                  req_ready_r, rsp_valid_r, rf_wen_r;
  logic [ADDR_WIDTH-1:0] rf_waddr_r;
  logic [DATA_WIDTH-1:0] rf_wdata_r;
  logic [DATA_WIDTH-1:0] rsp_data_a_r, rsp_data_b_r;

  assign hs_s = req_valid && (state_r == IDLE);

  // Next-state decode; reserved op is consumed in IDLE without leaving it.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (hs_s) begin
          case (req_op)
            2'b00:   state_s = RD;
            2'b01:   state_s = WR;
            2'b10:   state_s = CLR;
            default: state_s = IDLE;
          endcase
        end else begin
          state_s = IDLE;
        end
      end
      RD:  state_s = RSP;
      RSP: begin
        if (rsp_ready) state_s = IDLE;
        else           state_s = RSP;
      end
      WR:  state_s = IDLE;
      CLR: begin
        if (clr_cnt_r == ADDR_MAX) state_s = IDLE;
        else                       state_s = CLR;
      end
      default: state_s = IDLE;
    endcase
  end

  // Command latch and clear-sweep counter; the counter saturates instead of wrapping.
  always_comb begin
    addr_a_s  = addr_a_r;
    addr_b_s  = addr_b_r;
    wdata_s   = wdata_r;
    clr_cnt_s = clr_cnt_r;
    if (hs_s && (req_op != 2'b11)) begin
      addr_a_s = req_addr_a;
      addr_b_s = req_addr_b;
      wdata_s  = req_wdata;
    end else begin
      addr_a_s = addr_a_r;
    end
    if (hs_s && (req_op == 2'b10)) begin
      clr_cnt_s = ADDR_ONE;
    end else if ((state_r == CLR) && (clr_cnt_r != ADDR_MAX)) begin
      clr_cnt_s = clr_cnt_r + ADDR_ONE;
    end else begin
      clr_cnt_s = clr_cnt_r;
    end
  end

  // State, latches and outputs; outputs are registered from the next-state view.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      addr_a_r     <= ADDR_ZERO;
      addr_b_r     <= ADDR_ZERO;
      wdata_r      <= DATA_ZERO;
      clr_cnt_r    <= ADDR_ZERO;
      req_ready_r  <= 1'b1;
      rsp_valid_r  <= 1'b0;
      rf_wen_r     <= 1'b0;
      rf_waddr_r   <= ADDR_ZERO;
      rf_wdata_r   <= DATA_ZERO;
      rsp_data_a_r <= DATA_ZERO;
      rsp_data_b_r <= DATA_ZERO;
    end else begin
      state_r     <= state_s;
      addr_a_r    <= addr_a_s;
      addr_b_r    <= addr_b_s;
      wdata_r     <= wdata_s;
      clr_cnt_r   <= clr_cnt_s;
      req_ready_r <= (state_s == IDLE);
      rsp_valid_r <= (state_s == RSP);
      rf_wen_r    <= ((state_s == WR) && (addr_a_s != ADDR_ZERO)) || (state_s == CLR);
      rf_waddr_r  <= (state_s == CLR) ? clr_cnt_s : addr_a_s;
      rf_wdata_r  <= (state_s == CLR) ? DATA_ZERO : wdata_s;
      if (state_r == RD) begin
        rsp_data_a_r <= rf_rdata1;
        rsp_data_b_r <= rf_rdata2;
      end else begin
        rsp_data_a_r <= rsp_data_a_r;
        rsp_data_b_r <= rsp_data_b_r;
      end
    end
  end

  assign req_ready  = req_ready_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_data_a = rsp_data_a_r;
  assign rsp_data_b = rsp_data_b_r;
  assign rf_raddr1  = addr_a_r;
  assign rf_raddr2  = addr_b_r;
  assign rf_wen     = rf_wen_r;
  assign rf_waddr   = rf_waddr_r;
  assign rf_wdata   = rf_wdata_r;

endmodule

// File: tb/tb_rf_port_master.sv
// Randomized self-checking bench for rf_port_master with an attached register
// file and a register-content reference model.
module tb_rf_port_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [4:0]  req_addr_a = 5'd0;
  logic [4:0]  req_addr_b = 5'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data_a, rsp_data_b;
  logic [4:0]  rf_waddr, rf_raddr1, rf_raddr2;
  logic        rf_wen;
  logic [31:0] rf_wdata, rf_rdata1, rf_rdata2;

  logic [31:0] rf_mem  [32];
  logic [31:0] exp_mem [32];
  int          wen_count = 0;
  int          checks = 0;
  int          errors = 0;

  rf_port_master #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr_a(req_addr_a), .req_addr_b(req_addr_b), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data_a(rsp_data_a), .rsp_data_b(rsp_data_b),
    .rf_waddr(rf_waddr), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_wen(rf_wen), .rf_wdata(rf_wdata),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 32; i++) begin
      rf_mem[i]  = 32'd0;
      exp_mem[i] = 32'd0;
    end
  end

  // Register file attached to the master: combinational read, clocked write.
  always @(posedge clk) begin
    if (rf_wen) begin
      rf_mem[rf_waddr] <= rf_wdata;
      wen_count        <= wen_count + 1;
    end
  end
  assign rf_rdata1 = rf_mem[rf_raddr1];
  assign rf_rdata2 = rf_mem[rf_raddr2];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command and hold it until accepted; returns one cycle after the handshake.
  task automatic issue(input logic [1:0] op, input logic [4:0] a, input logic [4:0] b,
                       input logic [31:0] d);
    int n = 0;
    req_valid = 1'b1; req_op = op; req_addr_a = a; req_addr_b = b; req_wdata = d;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL issue_timeout: req_ready=%0b after %0d cycles, required 1", req_ready, n);
    end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    issue(2'b01, a, 5'd0, d);
    checks++;
    if (rf_wen !== (a != 5'd0)) begin
      errors++;
      $display("FAIL wr_wen: addr=%0d rf_wen=%0b required %0b", a, rf_wen, (a != 5'd0));
    end
    if (a != 5'd0) begin
      checks++;
      if (rf_waddr !== a || rf_wdata !== d) begin
        errors++;
        $display("FAIL wr_bus: waddr=%0d wdata=%h required %0d %h", rf_waddr, rf_wdata, a, d);
      end
      exp_mem[a] = d;
    end
    tick();
    checks++;
    if (req_ready !== 1'b1 || rf_wen !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL wr_done: ready=%0b wen=%0b rsp_valid=%0b required 1 0 0",
               req_ready, rf_wen, rsp_valid);
    end
  endtask

  task automatic do_read(input logic [4:0] a, input logic [4:0] b, input int hold);
    issue(2'b00, a, b, 32'd0);
    if (hold > 0) rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_early: rsp_valid=%0b in cycle N+1, required 0", rsp_valid);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data_a !== exp_mem[a] || rsp_data_b !== exp_mem[b]) begin
      errors++;
      $display("FAIL rd_rsp: a=%0d b=%0d valid=%0b data=%h/%h required 1 %h/%h",
               a, b, rsp_valid, rsp_data_a, rsp_data_b, exp_mem[a], exp_mem[b]);
    end
    for (int i = 0; i < hold; i++) begin
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 ||
          rsp_data_a !== exp_mem[a] || rsp_data_b !== exp_mem[b]) begin
        errors++;
        $display("FAIL rd_hold: cycle %0d valid=%0b ready=%0b data=%h/%h required 1 0 %h/%h",
                 i, rsp_valid, req_ready, rsp_data_a, rsp_data_b, exp_mem[a], exp_mem[b]);
      end
    end
    rsp_ready = 1'b1;
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rd_done: valid=%0b ready=%0b required 0 1", rsp_valid, req_ready);
    end
  endtask

  // Clear sweep; stop_at in 1..31 asserts reset during that sweep cycle.
  task automatic do_clear(input int stop_at);
    int start_count;
    start_count = wen_count;
    issue(2'b10, 5'd0, 5'd0, 32'd0);
    for (int k = 1; k <= 31; k++) begin
      checks++;
      if (rf_wen !== 1'b1 || rf_waddr !== 5'(k) || rf_wdata !== 32'd0 || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL clr_cycle: k=%0d wen=%0b waddr=%0d wdata=%h ready=%0b required 1 %0d 0 0",
                 k, rf_wen, rf_waddr, rf_wdata, req_ready, k);
      end
      if (k == stop_at) begin
        rst = 1'b1;
        tick();
        checks++;
        if (rf_wen !== 1'b0 || rsp_valid !== 1'b0) begin
          errors++;
          $display("FAIL clr_rst: wen=%0b rsp_valid=%0b required 0 0", rf_wen, rsp_valid);
        end
        rst = 1'b0;
        for (int j = 1; j <= k; j++) exp_mem[j] = 32'd0;
        tick();
        checks++;
        if (req_ready !== 1'b1 || rf_wen !== 1'b0 || rsp_data_a !== 32'd0) begin
          errors++;
          $display("FAIL clr_rst_idle: ready=%0b wen=%0b rsp_a=%h required 1 0 0",
                   req_ready, rf_wen, rsp_data_a);
        end
        return;
      end
      tick();
    end
    checks++;
    if (req_ready !== 1'b1 || rf_wen !== 1'b0) begin
      errors++;
      $display("FAIL clr_end: cycle 32 ready=%0b wen=%0b required 1 0", req_ready, rf_wen);
    end
    tick();
    tick();
    checks++;
    if (wen_count - start_count !== 31) begin
      errors++;
      $display("FAIL clr_pulses: %0d write pulses, required 31", wen_count - start_count);
    end
    for (int j = 1; j < 32; j++) exp_mem[j] = 32'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if (rf_wen !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_outs: wen=%0b rsp_valid=%0b required 0 0", rf_wen, rsp_valid);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (req_ready !== 1'b1 || rsp_data_a !== 32'd0 || rsp_data_b !== 32'd0 ||
        rf_raddr1 !== 5'd0 || rf_raddr2 !== 5'd0) begin
      errors++;
      $display("FAIL reset_state: ready=%0b data=%h/%h raddr=%0d/%0d required 1 0/0 0/0",
               req_ready, rsp_data_a, rsp_data_b, rf_raddr1, rf_raddr2);
    end
  endtask

  task automatic test_write_read();
    do_write(5'd5, 32'hDEADBEEF);
    do_read(5'd5, 5'd0, 0);
  endtask

  task automatic test_write_zero();
    do_write(5'd0, 32'h12345678);
    do_read(5'd0, 5'd0, 0);
  endtask

  task automatic test_backpressure();
    do_write(5'd9, 32'hA5A5_0F0F);
    do_read(5'd9, 5'd5, 5);
  endtask

  task automatic test_random();
    logic [4:0]  a, b;
    logic [31:0] d;
    for (int i = 0; i < 40; i++) begin
      a = 5'($urandom_range(0, 31));
      b = 5'($urandom_range(0, 31));
      d = $urandom;
      if ($urandom_range(0, 1) == 0) do_write(a, d);
      else                           do_read(a, b, int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_back_to_back();
    do_write(5'd3, 32'h0000_0333);
    do_write(5'd4, 32'h0000_0444);
    req_valid = 1'b1; req_op = 2'b00; req_addr_a = 5'd3; req_addr_b = 5'd4;
    tick();
    req_addr_a = 5'd4; req_addr_b = 5'd3;
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data_a !== exp_mem[3] || rsp_data_b !== exp_mem[4]) begin
      errors++;
      $display("FAIL b2b_first: valid=%0b data=%h/%h required 1 %h/%h",
               rsp_valid, rsp_data_a, rsp_data_b, exp_mem[3], exp_mem[4]);
    end
    tick();
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready: req_ready=%0b three cycles after first handshake, required 1", req_ready);
    end
    tick();
    req_valid = 1'b0;
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data_a !== exp_mem[4] || rsp_data_b !== exp_mem[3]) begin
      errors++;
      $display("FAIL b2b_second: valid=%0b data=%h/%h required 1 %h/%h",
               rsp_valid, rsp_data_a, rsp_data_b, exp_mem[4], exp_mem[3]);
    end
    tick();
  endtask

  task automatic test_clear();
    do_write(5'd1, 32'h1111_1111);
    do_write(5'd17, 32'h1717_1717);
    do_write(5'd31, 32'h3131_3131);
    do_clear(0);
    do_read(5'd1, 5'd17, 0);
    do_read(5'd31, 5'd12, 0);
  endtask

  task automatic test_reset_mid_clear();
    for (int i = 1; i < 32; i++) do_write(5'(i), ($urandom | 32'h1));
    do_clear(10);
    for (int i = 1; i < 31; i += 2) do_read(5'(i), 5'(i + 1), 0);
    do_read(5'd31, 5'd10, 0);
  endtask

  task automatic test_reserved();
    int start_count;
    start_count = wen_count;
    issue(2'b11, 5'd7, 5'd8, 32'hFFFF_FFFF);
    checks++;
    if (req_ready !== 1'b1 || rf_wen !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reserved_next: ready=%0b wen=%0b rsp_valid=%0b required 1 0 0",
               req_ready, rf_wen, rsp_valid);
    end
    repeat (3) tick();
    checks++;
    if (wen_count !== start_count || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reserved_quiet: %0d writes rsp_valid=%0b required 0 writes 0",
               wen_count - start_count, rsp_valid);
    end
    do_read(5'd7, 5'd8, 0);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_write_zero();
    test_backpressure();
    test_random();
    test_back_to_back();
    test_clear();
    test_reset_mid_clear();
    test_reserved();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_port_master.md
RF_PORT_MASTER -- requirements
Module: rf_port_master

Interface
REQ-001 Parameter: DATA_WIDTH, 32, width of one register word.
REQ-002 Parameter: ADDR_WIDTH, 5, register address width; register count is 1<<ADDR_WIDTH.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 Port: clk  in  1  single clock; all state changes on its rising edge.
REQ-005 Port: rst  in  1  synchronous reset, active high.
REQ-006 Port: req_valid  in  1  requester has a command.
REQ-007 Port: req_ready  out  1  block accepts a command this cycle.
REQ-008 Port: req_op  in  2  00 read, 01 write, 10 clear-all, 11 reserved.
REQ-009 Port: req_addr_a  in  ADDR_WIDTH  read address A, or write address.
REQ-010 Port: req_addr_b  in  ADDR_WIDTH  read address B.
REQ-011 Port: req_wdata  in  DATA_WIDTH  write data.
REQ-012 Port: rsp_valid  out  1  read response available.
REQ-013 Port: rsp_ready  in  1  consumer takes the response.
REQ-014 Port: rsp_data_a / rsp_data_b  out  DATA_WIDTH each  read results for A and B.
REQ-015 Port: rf_waddr, rf_raddr1, rf_raddr2  out  ADDR_WIDTH each  register-file addresses.
REQ-016 Port: rf_wen  out  1  register-file write enable; rf_wdata  out  DATA_WIDTH  register-file write data.
REQ-017 Port: rf_rdata1 / rf_rdata2  in  DATA_WIDTH each  combinational register-file read data.

Function
REQ-018 The FSM SHALL have states IDLE, RD, RSP, WR and CLR.
REQ-019 req_ready SHALL be 1 only in IDLE; a handshake occurs when req_valid and req_ready are both 1.
REQ-020 On a handshake, addr_a, addr_b, wdata and op SHALL be latched, and the next state SHALL be RD (op 00), WR (op 01) or CLR (op 10).
REQ-021 Op 11 SHALL be accepted and discarded; the block stays in IDLE with no side effects.
REQ-022 rf_raddr1 and rf_raddr2 SHALL always drive the latched addr_a and addr_b.
REQ-023 RD SHALL last one cycle, capture rf_rdata1 into rsp_data_a and rf_rdata2 into rsp_data_b, then go to RSP.
REQ-024 In RSP, rsp_valid SHALL be 1; rsp_data SHALL be held stable until rsp_ready is 1, then the next state SHALL be IDLE.
REQ-025 Read latency SHALL be 2 cycles: a handshake in cycle N gives rsp_valid at cycle N+2, with rsp_ready 1 in cycle N+2.
REQ-026 A back-to-back read handshake SHALL be possible in the cycle after the RSP handshake, giving a throughput of 1 read per 3 cycles.
REQ-027 WR SHALL last one cycle, driving rf_waddr = latched addr_a and rf_wdata = latched wdata.
REQ-028 In WR, rf_wen SHALL be 1 only if addr_a != 0; a write to register 0 SHALL complete silently with rf_wen = 0.
REQ-029 Writes SHALL produce no response.
REQ-030 CLR SHALL use an ADDR_WIDTH counter starting at 1 and drive rf_wen = 1, rf_waddr = counter and rf_wdata = 0 for each cycle.
REQ-031 The CLR counter SHALL increment each cycle; after writing address (1<<ADDR_WIDTH)-1 (31 cycles total), the next state SHALL be IDLE.
REQ-032 The CLR counter SHALL NOT wrap to 0.
REQ-033 rf_wen SHALL be 0 in every state except WR (nonzero address) and CLR.
REQ-034 rsp_valid SHALL be 0 outside RSP.

Reset
REQ-035 On rst = 1 at a clock edge, the FSM SHALL go to IDLE regardless of state, including mid-CLR or RSP.
REQ-036 On reset, the latched addresses, wdata and CLR counter SHALL be cleared to 0, and rsp_data_a and rsp_data_b SHALL be cleared to 0.
REQ-037 During and after reset: rf_wen = 0, rsp_valid = 0, and req_ready = 1 from the first cycle after reset deasserts.
REQ-038 A reset during CLR SHALL abandon the sweep; registers already cleared stay cleared.

Verification
REQ-039 Write then read: write addr 5 with data 0xDEADBEEF, then read A=5, B=0 -> rsp_valid 2 cycles after the read handshake, rsp_data_a = 0xDEADBEEF, rsp_data_b = 0.
REQ-040 Write to register 0: write addr 0 with data 0x12345678 -> rf_wen stays 0; a subsequent read of 0 returns 0.
REQ-041 Response backpressure: hold rsp_ready = 0 for 5 cycles in RSP -> rsp_valid stays 1, rsp_data is unchanged, req_ready = 0 throughout.
REQ-042 Clear-all: preload regs 1, 17 and 31 with nonzero values, issue op 10 -> exactly 31 rf_wen pulses on addresses 1..31, req_ready returns 1 on cycle 32, and all reads return 0.
REQ-043 Reset mid-clear: assert rst at CLR cycle 10 -> next cycle is IDLE with rf_wen = 0; registers 1..10 are cleared and registers 11..31 are unchanged.
REQ-044 Op 11: issue a reserved op -> accepted, no rf_wen, no rsp_valid, and req_ready = 1 on the next cycle.
